mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter ADDR_BASE, default 64'h0000_0000_8000_0000, SHALL be the byte address of the first backing-store doubleword.
REQ-002 Parameter DEPTH_DW, default 1024, SHALL be the backing-store size in 64-bit doublewords.
REQ-003 Parameter LATENCY, default 2, legal range 1..15, SHALL be the number of cycles from request acceptance to mem_ready.
REQ-004 Port clock, input, 1: the single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port mem_valid, input, 1: request present from the memory stage.
REQ-007 Port mem_req, input, 1: 0 = read, 1 = write.
REQ-008 Port mem_addr, input, 64: byte address.
REQ-009 Port mem_size, input, 2: 00 = B, 01 = H, 10 = W, 11 = D.
REQ-010 Port mem_wdata, input, 64: write data, right-aligned (operand in low bits).
REQ-011 Port mem_ready, output, 1: one-cycle completion pulse.
REQ-012 Port mem_rdata, output, 64: read data, right-aligned, zero-extended to 64 bits.
REQ-013 Port mem_resp, output, 2: 00 = OKAY, 10 = SLVERR (misaligned), 11 = DECERR (out of range).

Function
REQ-014 FSM states SHALL be IDLE, WAIT, RESP.
REQ-015 IDLE: mem_valid=1 at a rising edge SHALL latch req, addr, size and wdata, and SHALL move to RESP if LATENCY=1, else to WAIT.
REQ-016 WAIT: a down-counter loaded with LATENCY-1 at acceptance SHALL decrement once per cycle; the FSM SHALL move to RESP on the edge where the count is 1.
REQ-017 RESP: mem_ready SHALL be 1 for exactly this one cycle; the FSM SHALL then return to IDLE unconditionally.
REQ-018 Timing: for acceptance at edge T, mem_ready SHALL be high during the cycle after edge T+LATENCY-1.
REQ-019 mem_valid SHALL be ignored in WAIT and RESP; latched fields SHALL NOT change after acceptance.
REQ-020 A request presented in the cycle after RESP SHALL be accepted, giving back-to-back throughput of one access per LATENCY+1 cycles.
REQ-021 Misaligned means: H with addr[0]=1; W with addr[1:0]!=0; D with addr[2:0]!=0. B is never misaligned.
REQ-022 Out of range means: addr < ADDR_BASE or addr >= ADDR_BASE + 8*DEPTH_DW. Out of range SHALL take priority over misaligned.
REQ-023 Doubleword index SHALL be (addr - ADDR_BASE) >> 3; lane offset SHALL be addr[2:0].
REQ-024 Write with OKAY: bytes [size_bytes-1:0] of wdata SHALL be written to lanes offset..offset+size_bytes-1 of the indexed doubleword on the edge ending the RESP cycle. Other lanes SHALL be unchanged.
REQ-025 Read with OKAY: mem_rdata SHALL equal (doubleword >> 8*offset) masked to size_bytes bytes, with upper bits zero, valid during the RESP cycle.
REQ-026 Any error response SHALL perform no write and SHALL drive mem_rdata = 0.
REQ-027 Outside RESP, mem_ready SHALL be 0, mem_rdata 0, and mem_resp 00.
REQ-028 A read issued after a write to the same address SHALL return the newly written data; there is no forwarding hazard because accesses are serialized.

Reset
REQ-029 Reset SHALL force FSM=IDLE, counter=0, mem_ready=0, mem_rdata=0, mem_resp=00.
REQ-030 Reset asserted in WAIT or RESP SHALL abort the access, with no memory write and no mem_ready pulse.
REQ-031 Backing-store contents SHALL NOT be cleared by reset.
REQ-032 mem_valid high while reset is high SHALL NOT be accepted.

Verification
REQ-033 LATENCY=2: write D, addr 8000_0000, data 1122334455667788; then read D at the same address -> each mem_ready pulse arrives 2 cycles after acceptance, the read returns 1122334455667788, and mem_resp=00.
REQ-034 Write B 0xAB at 8000_0003 over 1122334455667788, then read D -> 11223344AB667788; read B at 8000_0003 -> 00000000000000AB.
REQ-035 Read H at 8000_0001 -> mem_resp=10 and mem_rdata=0; a following read D shows no write occurred.
REQ-036 Read W at 7FFF_FFF8, and again at ADDR_BASE+8*DEPTH_DW -> mem_resp=11, no write, single mem_ready pulse each.
REQ-037 Assert reset during WAIT of a write D at 8000_0010 -> no mem_ready pulse; a following read D there returns its prior value.
REQ-038 LATENCY=1, back-to-back reads -> mem_ready every 2nd cycle; mem_valid held high during WAIT/RESP causes no extra acceptance.

Source files
------------

// File: rtl/mem_responder.sv
// Fixed-latency memory responder: one serialized access at a time, with a
// doubleword backing store, misalignment and address-range error responses.
module mem_responder #(
    parameter logic [63:0] ADDR_BASE = 64'h0000_0000_8000_0000,
    parameter int          DEPTH_DW  = 1024,
    parameter int          LATENCY   = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic        mem_req,
    input  logic [63:0] mem_addr,
    input  logic [1:0]  mem_size,
    input  logic [63:0] mem_wdata,
    output logic        mem_ready,
    output logic [63:0] mem_rdata,
    output logic [1:0]  mem_resp
);

    localparam int          IDX_W = $clog2(DEPTH_DW);
    localparam logic [63:0] SPAN  = 64'(DEPTH_DW) * 64'd8;

    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

    function automatic logic [63:0] size_mask(input logic [1:0] size);
        case (size)
            2'b00:   size_mask = 64'h0000_0000_0000_00FF;
            2'b01:   size_mask = 64'h0000_0000_0000_FFFF;
            2'b10:   size_mask = 64'h0000_0000_FFFF_FFFF;
            default: size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [2:0] lane);
        case (size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = lane[0];
            2'b10:   misaligned = (lane[1:0] != 2'b00);
            default: misaligned = (lane != 3'b000);
        endcase
    endfunction

    state_t      state_r, state_nx_s;
    logic [3:0]  cnt_r, cnt_nx_s;
    logic        accept_s;
    logic        req_r;
    logic [63:0] addr_r, wdata_r;
    logic [1:0]  size_r;
    logic [63:0] mem_r [DEPTH_DW];

    logic        src_req_s;
    logic [63:0] src_addr_s;
    logic [1:0]  src_size_s;
    logic [63:0] off_s;
    logic [IDX_W-1:0] idx_s;
    logic [5:0]  shamt_s;
    logic [1:0]  resp_s;
    logic [63:0] rd_s;
    logic [63:0] wmask_s;

    // State and countdown registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_nx_s;
            cnt_r   <= cnt_nx_s;
        end
    end

    // Next-state and countdown logic
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        accept_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (mem_valid) begin
                    accept_s = 1'b1;
                    cnt_nx_s = 4'(LATENCY - 1);
                    if (LATENCY == 1) begin
                        state_nx_s = RESP;
                    end else begin
                        state_nx_s = WAIT;
                    end
                end else begin
                    state_nx_s = IDLE;
                end
            end
            WAIT: begin
                if (cnt_r == 4'd1) begin
                    state_nx_s = RESP;
                    cnt_nx_s   = 4'd0;
                end else begin
                    cnt_nx_s   = cnt_r - 4'd1;
                end
            end
            RESP:    state_nx_s = IDLE;
            default: state_nx_s = IDLE;
        endcase
    end

    // Request capture at acceptance; held stable until the next acceptance
    always_ff @(posedge clock) begin
        if (reset) begin
            req_r   <= 1'b0;
            addr_r  <= 64'd0;
            size_r  <= 2'b00;
            wdata_r <= 64'd0;
        end else if (accept_s) begin
            req_r   <= mem_req;
            addr_r  <= mem_addr;
            size_r  <= mem_size;
            wdata_r <= mem_wdata;
        end
    end

    // With LATENCY=1 the response is formed on the acceptance edge, so decode
    // straight from the inputs while idle and from the captured fields otherwise.
    always_comb begin
        if (state_r == IDLE) begin
            src_req_s  = mem_req;
            src_addr_s = mem_addr;
            src_size_s = mem_size;
        end else begin
            src_req_s  = req_r;
            src_addr_s = addr_r;
            src_size_s = size_r;
        end
        off_s   = src_addr_s - ADDR_BASE;
        idx_s   = off_s[IDX_W+2:3];
        shamt_s = {src_addr_s[2:0], 3'b000};
        if ((src_addr_s < ADDR_BASE) || (off_s >= SPAN)) begin
            resp_s = 2'b11;
        end else if (misaligned(src_size_s, src_addr_s[2:0])) begin
            resp_s = 2'b10;
        end else begin
            resp_s = 2'b00;
        end
        rd_s    = (mem_r[idx_s] >> shamt_s) & size_mask(src_size_s);
        wmask_s = size_mask(src_size_s) << shamt_s;
    end

    // Registered response, asserted only for the RESP cycle
    always_ff @(posedge clock) begin
        if (reset) begin
            mem_ready <= 1'b0;
            mem_resp  <= 2'b00;
            mem_rdata <= 64'd0;
        end else if (state_nx_s == RESP) begin
            mem_ready <= 1'b1;
            mem_resp  <= resp_s;
            mem_rdata <= (!src_req_s && resp_s == 2'b00) ? rd_s : 64'd0;
        end else begin
            mem_ready <= 1'b0;
            mem_resp  <= 2'b00;
            mem_rdata <= 64'd0;
        end
    end

    // Backing-store write on the edge ending RESP; contents survive reset
    always_ff @(posedge clock) begin
        if (!reset && state_r == RESP && req_r && resp_s == 2'b00) begin
            mem_r[idx_s] <= (mem_r[idx_s] & ~wmask_s) | ((wdata_r << shamt_s) & wmask_s);
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Randomized bench for mem_responder against a byte-level reference model,
// with one instance at LATENCY=2 and one at LATENCY=1.
module tb_mem_responder;

    localparam logic [63:0] BASE  = 64'h0000_0000_8000_0000;
    localparam int          DEPTH = 1024;

    logic        clock = 1'b0;
    logic        reset;
    logic        mem_valid, mem_req, use1;
    logic [63:0] mem_addr, mem_wdata;
    logic [1:0]  mem_size;
    logic        valid1, valid2, ready1, ready2, ready_m;
    logic [63:0] rdata1, rdata2, rdata_m;
    logic [1:0]  resp1, resp2, resp_m;

    int vectors = 0;
    int miscompares = 0;
    logic [63:0] ref_mem [2][DEPTH];

    assign valid2  = mem_valid & ~use1;
    assign valid1  = mem_valid & use1;
    assign ready_m = use1 ? ready1 : ready2;
    assign rdata_m = use1 ? rdata1 : rdata2;
    assign resp_m  = use1 ? resp1  : resp2;

    always #5 clock = ~clock;

    mem_responder #(.LATENCY(2)) dut2 (
        .clock(clock), .reset(reset), .mem_valid(valid2), .mem_req(mem_req),
        .mem_addr(mem_addr), .mem_size(mem_size), .mem_wdata(mem_wdata),
        .mem_ready(ready2), .mem_rdata(rdata2), .mem_resp(resp2)
    );

    mem_responder #(.LATENCY(1)) dut1 (
        .clock(clock), .reset(reset), .mem_valid(valid1), .mem_req(mem_req),
        .mem_addr(mem_addr), .mem_size(mem_size), .mem_wdata(mem_wdata),
        .mem_ready(ready1), .mem_rdata(rdata1), .mem_resp(resp1)
    );

    // Reference: classify the access, then move individual bytes.
    task automatic model(input int d, input logic req, input logic [63:0] addr,
                         input logic [1:0] size, input logic [63:0] wdata,
                         output logic [1:0] resp, output logic [63:0] rdata);
        int nb;
        int idx;
        int off;
        nb = 1 << size;
        rdata = 64'd0;
        if (addr < BASE || addr >= BASE + 64'(DEPTH) * 64'd8) begin
            resp = 2'b11;
        end else if (addr % 64'(nb) != 64'd0) begin
            resp = 2'b10;
        end else begin
            resp = 2'b00;
            idx = int'((addr - BASE) / 64'd8);
            off = int'(addr % 64'd8);
            for (int b = 0; b < nb; b++) begin
                if (req) ref_mem[d][idx][8*(off+b) +: 8] = wdata[8*b +: 8];
                else     rdata[8*b +: 8] = ref_mem[d][idx][8*(off+b) +: 8];
            end
        end
    endtask

    // One access on the selected instance; caller is at a falling edge.
    task automatic txn(input logic req, input logic [63:0] addr, input logic [1:0] size,
                       input logic [63:0] wdata, input string tag,
                       output logic [63:0] rd, output logic [1:0] rs);
        int n;
        int lat_exp;
        logic got;
        logic [1:0]  exp_resp;
        logic [63:0] exp_rdata;
        lat_exp = use1 ? 1 : 2;
        mem_valid = 1'b1; mem_req = req; mem_addr = addr; mem_size = size; mem_wdata = wdata;
        @(posedge clock);
        n = 0;
        got = 1'b0;
        while (n < 20 && !got) begin
            @(negedge clock);
            n++;
            if (ready_m) got = 1'b1;
            if (n == 1) begin
                mem_valid = 1'b0;
                mem_req   = 1'($urandom);
                mem_addr  = {$urandom, $urandom};
                mem_size  = 2'($urandom);
                mem_wdata = {$urandom, $urandom};
            end
        end
        rd = rdata_m;
        rs = resp_m;
        model(use1 ? 1 : 0, req, addr, size, wdata, exp_resp, exp_rdata);
        vectors++;
        if (!got) begin
            miscompares++;
            $display("FAIL %s timeout: no mem_ready within 20 cycles", tag);
        end else begin
            if (n !== lat_exp) begin
                miscompares++;
                $display("FAIL %s latency: got %0d required %0d", tag, n, lat_exp);
            end
            vectors++;
            if (rs !== exp_resp) begin
                miscompares++;
                $display("FAIL %s resp: got %b required %b", tag, rs, exp_resp);
            end
            vectors++;
            if (rd !== exp_rdata) begin
                miscompares++;
                $display("FAIL %s rdata: got %h required %h", tag, rd, exp_rdata);
            end
            @(negedge clock);
            vectors++;
            if ({ready_m, resp_m, rdata_m} !== 67'd0) begin
                miscompares++;
                $display("FAIL %s after_pulse: got ready=%b resp=%b rdata=%h required all zero",
                         tag, ready_m, resp_m, rdata_m);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; use1 = 1'b0;
        mem_valid = 1'b1; mem_req = 1'b0; mem_addr = BASE; mem_size = 2'b11; mem_wdata = 64'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            vectors++;
            if ({ready1, resp1, rdata1, ready2, resp2, rdata2} !== 134'd0) begin
                miscompares++;
                $display("FAIL reset_outputs: got r1=%b r2=%b resp=%b/%b required zeros",
                         ready1, ready2, resp1, resp2);
            end
        end
        mem_valid = 1'b0;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            vectors++;
            if (ready1 !== 1'b0 || ready2 !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_no_accept: got ready %b/%b required 0/0", ready1, ready2);
            end
        end
    endtask

    task automatic lit(input string tag, input logic [63:0] got, input logic [63:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h required %h", tag, got, want);
        end
    endtask

    task automatic test_directed();
        logic [63:0] rd;
        logic [1:0]  rs;
        use1 = 1'b0;
        txn(1'b1, BASE, 2'b11, 64'h1122334455667788, "w_d", rd, rs);
        txn(1'b0, BASE, 2'b11, 64'd0, "r_d", rd, rs);
        lit("r_d_value", rd, 64'h1122334455667788);
        txn(1'b1, BASE + 64'd3, 2'b00, 64'h0000_0000_0000_00AB, "w_b", rd, rs);
        txn(1'b0, BASE, 2'b11, 64'd0, "r_d_merged", rd, rs);
        lit("r_d_merged_value", rd, 64'h11223344AB667788);
        txn(1'b0, BASE + 64'd3, 2'b00, 64'd0, "r_b", rd, rs);
        lit("r_b_value", rd, 64'h0000_0000_0000_00AB);
        txn(1'b0, BASE + 64'd1, 2'b01, 64'd0, "r_h_misaligned", rd, rs);
        lit("r_h_misaligned_resp", 64'(rs), 64'd2);
        txn(1'b1, BASE + 64'd1, 2'b01, 64'hFFFF, "w_h_misaligned", rd, rs);
        txn(1'b0, BASE, 2'b11, 64'd0, "r_d_unchanged", rd, rs);
        lit("r_d_unchanged_value", rd, 64'h11223344AB667788);
        txn(1'b0, BASE - 64'd8, 2'b10, 64'd0, "r_w_below", rd, rs);
        lit("r_w_below_resp", 64'(rs), 64'd3);
        txn(1'b0, BASE + 64'(DEPTH) * 64'd8, 2'b10, 64'd0, "r_w_above", rd, rs);
        lit("r_w_above_resp", 64'(rs), 64'd3);
    endtask

    task automatic test_reset_abort();
        logic [63:0] rd;
        logic [1:0]  rs;
        use1 = 1'b0;
        txn(1'b1, BASE + 64'd16, 2'b11, 64'hCAFEF00DDEADBEEF, "abort_init", rd, rs);
        mem_valid = 1'b1; mem_req = 1'b1; mem_addr = BASE + 64'd16;
        mem_size = 2'b11; mem_wdata = 64'h0123456789ABCDEF;
        @(posedge clock);
        @(negedge clock);
        mem_valid = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (ready2 !== 1'b0) begin
                miscompares++;
                $display("FAIL abort_no_ready: got %b required 0 at step %0d", ready2, i);
            end
            if (i == 1) reset = 1'b0;
            @(negedge clock);
        end
        txn(1'b0, BASE + 64'd16, 2'b11, 64'd0, "abort_readback", rd, rs);
        lit("abort_readback_value", rd, 64'hCAFEF00DDEADBEEF);
    endtask

    task automatic test_random();
        logic [63:0] rd, addr;
        logic [1:0]  rs;
        int pick;
        use1 = 1'b0;
        for (int i = 0; i < 8; i++)
            txn(1'b1, BASE + 64'(8 * i), 2'b11, {$urandom, $urandom}, "rand_init", rd, rs);
        for (int i = 0; i < 150; i++) begin
            pick = int'($urandom_range(0, 9));
            if (pick == 0)      addr = BASE - 64'($urandom_range(1, 16));
            else if (pick == 1) addr = BASE + 64'(DEPTH) * 64'd8 + 64'($urandom_range(0, 16));
            else                addr = BASE + 64'($urandom_range(0, 63));
            txn(1'($urandom), addr, 2'($urandom), {$urandom, $urandom}, "rand", rd, rs);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] rd;
        logic [1:0]  rs;
        logic        exp_ready;
        use1 = 1'b1;
        txn(1'b1, BASE + 64'd40, 2'b11, {$urandom, $urandom}, "b2b_init", rd, rs);
        mem_valid = 1'b1; mem_req = 1'b0; mem_addr = BASE + 64'd40; mem_size = 2'b11;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clock);
            exp_ready = 1'(k % 2);
            vectors++;
            if (ready1 !== exp_ready) begin
                miscompares++;
                $display("FAIL b2b_ready[%0d]: got %b required %b", k, ready1, exp_ready);
            end
            if (exp_ready) begin
                vectors++;
                if (rdata1 !== ref_mem[1][5] || resp1 !== 2'b00) begin
                    miscompares++;
                    $display("FAIL b2b_data[%0d]: got %h/%b required %h/00", k, rdata1, resp1, ref_mem[1][5]);
                end
            end
        end
        mem_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            vectors++;
            if (ready1 !== 1'b0) begin
                miscompares++;
                $display("FAIL b2b_drain[%0d]: got %b required 0", k, ready1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_reset_abort();
        test_random();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
